subcore_dispatcher: RTL and testbench
=====================================

# subcore_dispatcher

Schedules fork requests from the main core onto the pool of `SUBCORE_NUM` subcores. It buffers pending fork PCs in a small FIFO and picks an idle subcore round-robin. It drives each subcore's one-cycle `exec_requested` launch pulse with a held `requested_pc`, and tracks per-subcore busy state from `subcore_ended`. It also answers the main core's join (barrier) request once all work has drained. It sits between `main` and the `sub` instances, replacing the direct per-subcore request wiring.

## Interface
- `SUBCORE_NUM`, 4: number of subcores; ≥1.
- `QDEPTH`, 4: pending-fork FIFO depth; power of two, ≥2.

Ports:
- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `fork_valid`  in  1  main core offers a fork.
- `fork_pc`  in  32  start PC of the forked task.
- `fork_ready`  out  1  FIFO can accept; fork accepted on edge where `fork_valid && fork_ready`.
- `join_req`  in  1  main core waits for all subcores; level.
- `join_done`  out  1  barrier satisfied; registered level.
- `exec_requested`  out  SUBCORE_NUM  per-subcore launch pulse.
- `requested_pc`  out  32*SUBCORE_NUM  per-subcore PC; subcore i at bits [32i+31:32i].
- `subcore_ended`  in  SUBCORE_NUM  per-subcore completion, sampled only in RUN.
- `busy_mask`  out  SUBCORE_NUM  bit i = subcore i in LAUNCH or RUN.
- `dispatch_count`  out  32  perf: tasks launched.
- `stall_cycles`  out  32  perf: cycles FIFO non-empty with no idle subcore.

## Operation
- Per-subcore FSM with states IDLE, LAUNCH and RUN.
  - IDLE→LAUNCH on grant.
  - LAUNCH→RUN unconditionally after one cycle.
  - RUN→IDLE on an edge where `subcore_ended[i]`=1.
  - `subcore_ended` is ignored in IDLE and LAUNCH.
- `exec_requested[i]` = 1 exactly while in LAUNCH.
- `requested_pc[i]` is loaded at the grant edge and held unchanged until the next grant to i.
- Dispatch runs each cycle if the FIFO is non-empty and at least one subcore is IDLE.
  - Pop the head and grant it to the first IDLE subcore searching from `rr` upward, modulo `SUBCORE_NUM`.
  - After the grant, `rr` ← granted index + 1 (mod N).
  - At most one grant per cycle.
- `fork_ready` = !full && !rst.
  - It does not depend on a same-cycle pop, so there is no pass-through when full.
  - A full FIFO drops nothing; the main core holds `fork_valid`/`fork_pc`.
- Push and pop in the same cycle are both performed; occupancy is unchanged.
- Pointers are log2(QDEPTH)+1 bits.
  - Empty when pointers are equal.
  - Full when the MSBs differ and the low bits are equal.
  - Wrap-around is natural.
- `join_done` register ← `join_req` && FIFO empty && all IDLE && !(`fork_valid && fork_ready`).
  - A fork accepted in the same cycle blocks the join.
- A subcore that ends frees at that edge and is grantable from the next edge onward; it cannot end and relaunch at the same edge.

## Timing
- Reset (synchronous, wins over everything):
  - FIFO emptied, `rr`=0, all FSMs IDLE.
  - `exec_requested`=0, `requested_pc`=0, `busy_mask`=0, `join_done`=0, perf counters=0.
  - `fork_ready`=0 while `rst`=1.
- Reset mid-operation abandons running subcores and pending forks; no pulse is issued afterwards for pre-reset work.
- Fork latency with an idle subcore:
  - Accepted at edge E0.
  - Grant at E1; `exec_requested[i]` high from E1 to E2.
  - `busy_mask[i]` set from E1.
- Join latency: `join_done` rises one edge after the condition first holds, and falls one edge after the condition drops.
- Throughput: one launch per cycle while work and idle subcores exist.

## Configuration
- `DISPATCH_PERF_EN` defined:
  - `dispatch_count` increments on every grant.
  - `stall_cycles` increments on each cycle with FIFO non-empty and no IDLE subcore.
  - Both counters wrap at 2^32.
- Not defined: both ports are constant 0, the counter registers are not synthesized, and all other behaviour is identical.

## Test plan
- Single fork: reset, then one fork with pc=0x100 → `exec_requested`=0001 one cycle later for exactly one cycle; `requested_pc[0]`=0x100; `busy_mask`=0001 until `subcore_ended[0]` pulses, then 0000.
- Round-robin: 5 back-to-back forks with PCs 0x10–0x50, N=4, no ends.
  - Subcores 0,1,2,3 launched on consecutive cycles.
  - 5th fork stays queued and `stall_cycles` increments.
  - Pulse `subcore_ended[2]` → 0x50 launched on subcore 2 the next cycle.
- Backpressure: all subcores busy, push 4 forks → `fork_ready`=0 after the 4th; a 5th held `fork_valid` is accepted only after a subcore ends and a pop occurs.
- Join: `join_req`=1 with 2 subcores running → `join_done`=0 until both end; rises one cycle after the last end; a fork accepted the same cycle suppresses it.
- Reset mid-op: 3 subcores running and 2 queued, assert `rst` one cycle → all outputs 0; no `exec_requested` afterwards without new forks; the next fork goes to subcore 0.
- Ended ignored: `subcore_ended[1]` held high during subcore 1's LAUNCH cycle → state still advances to RUN; it frees on the next edge where `subcore_ended[1]` is high in RUN.

Source files
------------

// File: rtl/subcore_dispatcher_if.sv
// Fork/join/launch bundle between the main core, the subcore dispatcher and the subcore pool.
// The dispatcher takes the slave modport; the main-core/subcore side takes master.
interface subcore_dispatcher_if #(
    parameter int unsigned SUBCORE_NUM = 4
);
    logic                      fork_valid;
    logic [31:0]               fork_pc;
    logic                      fork_ready;
    logic                      join_req;
    logic                      join_done;
    logic [SUBCORE_NUM-1:0]    exec_requested;
    logic [32*SUBCORE_NUM-1:0] requested_pc;
    logic [SUBCORE_NUM-1:0]    subcore_ended;
    logic [SUBCORE_NUM-1:0]    busy_mask;
    logic [31:0]               dispatch_count;
    logic [31:0]               stall_cycles;

    modport master (
        output fork_valid, fork_pc, join_req, subcore_ended,
        input  fork_ready, join_done, exec_requested, requested_pc, busy_mask,
        input  dispatch_count, stall_cycles
    );

    modport slave (
        input  fork_valid, fork_pc, join_req, subcore_ended,
        output fork_ready, join_done, exec_requested, requested_pc, busy_mask,
        output dispatch_count, stall_cycles
    );
endinterface

// File: rtl/subcore_dispatcher.sv
// Queues fork PCs and launches them round-robin onto idle subcores; answers join barriers.
// Define DISPATCH_PERF_EN to build the dispatch/stall performance counters.
module subcore_dispatcher #(
    parameter int unsigned SUBCORE_NUM = 4,
    parameter int unsigned QDEPTH      = 4
) (
    input logic                 clk,
    input logic                 rst,
    subcore_dispatcher_if.slave bus
);
    localparam int unsigned AddrW = $clog2(QDEPTH);
    localparam int unsigned PtrW  = AddrW + 1;
    localparam int unsigned IdxW  = (SUBCORE_NUM > 1) ? $clog2(SUBCORE_NUM) : 1;

    typedef enum logic [1:0] {StIdle, StLaunch, StRun} state_e;

    logic [31:0]            fifo_q [QDEPTH];
    logic [PtrW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic                   empty, full, push, pop;

    state_e                 state_q [SUBCORE_NUM];
    state_e                 state_d [SUBCORE_NUM];
    logic [31:0]            pc_q [SUBCORE_NUM];
    logic [IdxW-1:0]        rr_q, rr_d, gnt_idx;
    logic [SUBCORE_NUM-1:0] idle, launch, grant;
    logic                   join_done_q, join_done_d;
    logic                   found;
    int unsigned            cand;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[PtrW-1] != rd_ptr_q[PtrW-1]) &&
                   (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]);

    // Ready is independent of a same-cycle pop: no pass-through while full.
    assign bus.fork_ready = !full && !rst;
    assign push           = bus.fork_valid && bus.fork_ready;
    assign pop            = !empty && (|idle);

    assign wr_ptr_d = wr_ptr_q + PtrW'(push);
    assign rd_ptr_d = rd_ptr_q + PtrW'(pop);

    always_comb begin
        idle   = '0;
        launch = '0;
        for (int i = 0; i < SUBCORE_NUM; i++) begin
            idle[i]   = (state_q[i] == StIdle);
            launch[i] = (state_q[i] == StLaunch);
        end
    end

    // First idle subcore at or after rr, wrapping.
    always_comb begin
        found   = 1'b0;
        gnt_idx = '0;
        cand    = 0;
        for (int unsigned k = 0; k < SUBCORE_NUM; k++) begin
            cand = (32'(rr_q) + k) % SUBCORE_NUM;
            if (!found && idle[IdxW'(cand)]) begin
                found   = 1'b1;
                gnt_idx = IdxW'(cand);
            end
        end
    end

    always_comb begin
        grant = '0;
        rr_d  = rr_q;
        if (pop) begin
            grant[gnt_idx] = 1'b1;
            rr_d = (32'(gnt_idx) == SUBCORE_NUM - 1) ? '0 : gnt_idx + IdxW'(1);
        end
    end

    always_comb begin
        for (int i = 0; i < SUBCORE_NUM; i++) begin
            state_d[i] = state_q[i];
            unique case (state_q[i])
                StIdle:   if (grant[i]) state_d[i] = StLaunch;
                StLaunch: state_d[i] = StRun;
                StRun:    if (bus.subcore_ended[i]) state_d[i] = StIdle;
                default:  state_d[i] = StIdle;
            endcase
        end
    end

    // A fork accepted this cycle keeps the barrier open.
    assign join_done_d = bus.join_req && empty && (&idle) && !push;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            rr_q        <= '0;
            join_done_q <= 1'b0;
            for (int i = 0; i < SUBCORE_NUM; i++) begin
                state_q[i] <= StIdle;
                pc_q[i]    <= '0;
            end
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            rr_q        <= rr_d;
            join_done_q <= join_done_d;
            for (int i = 0; i < SUBCORE_NUM; i++) begin
                state_q[i] <= state_d[i];
                if (grant[i]) pc_q[i] <= fifo_q[rd_ptr_q[AddrW-1:0]];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_q[wr_ptr_q[AddrW-1:0]] <= bus.fork_pc;
    end

    for (genvar g = 0; g < SUBCORE_NUM; g++) begin : g_pc
        assign bus.requested_pc[32*g +: 32] = pc_q[g];
    end

    assign bus.exec_requested = launch;
    assign bus.busy_mask      = ~idle;
    assign bus.join_done      = join_done_q;

`ifdef DISPATCH_PERF_EN
    logic [31:0] dispatch_count_q, stall_cycles_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            dispatch_count_q <= '0;
            stall_cycles_q   <= '0;
        end else begin
            if (pop) dispatch_count_q <= dispatch_count_q + 32'd1;
            if (!empty && !(|idle)) stall_cycles_q <= stall_cycles_q + 32'd1;
        end
    end

    assign bus.dispatch_count = dispatch_count_q;
    assign bus.stall_cycles   = stall_cycles_q;
`else
    assign bus.dispatch_count = '0;
    assign bus.stall_cycles   = '0;
`endif

endmodule

// File: tb/tb_subcore_dispatcher.sv
// Directed plus randomized bench for subcore_dispatcher against a queue-based reference model.
module tb_subcore_dispatcher;
    localparam int unsigned N = 4;
    localparam int unsigned Q = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    subcore_dispatcher_if #(.SUBCORE_NUM(N)) bus ();
    subcore_dispatcher #(.SUBCORE_NUM(N), .QDEPTH(Q)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_vec  = 0;
    int n_miss = 0;

    // Reference model: pending PCs, per-subcore busy flag, "launched at the last edge" flag.
    logic [31:0] m_q [$];
    bit          m_busy   [N];
    bit          m_launch [N];
    logic [31:0] m_pc     [N];
    int          m_rr;
    bit          m_join;
    logic [31:0] m_disp, m_stall;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input bit r, input bit fv, input logic [31:0] pc, input bit jr,
                              input logic [N-1:0] en, output bit acc);
        bit idle_any, busy_any;
        int g;
        idle_any = 0;
        busy_any = 0;
        g        = -1;
        acc      = 0;
        if (r) begin
            m_q.delete();
            for (int i = 0; i < N; i++) begin
                m_busy[i]   = 0;
                m_launch[i] = 0;
                m_pc[i]     = '0;
            end
            m_rr    = 0;
            m_join  = 0;
            m_disp  = '0;
            m_stall = '0;
        end else begin
            acc = fv && (m_q.size() < Q);
            for (int i = 0; i < N; i++) begin
                if (m_busy[i]) busy_any = 1;
                else           idle_any = 1;
            end
            m_join = jr && (m_q.size() == 0) && !busy_any && !acc;
            if (m_q.size() > 0 && !idle_any) m_stall++;
            if (m_q.size() > 0) begin
                for (int k = 0; k < N; k++) begin
                    if (g < 0 && !m_busy[(m_rr + k) % N]) g = (m_rr + k) % N;
                end
            end
            for (int i = 0; i < N; i++) begin
                if (m_launch[i])                m_launch[i] = 0;
                else if (m_busy[i] && en[i])    m_busy[i]   = 0;
            end
            if (g >= 0) begin
                m_pc[g]     = m_q.pop_front();
                m_busy[g]   = 1;
                m_launch[g] = 1;
                m_rr        = (g + 1) % N;
                m_disp++;
            end
            if (acc) m_q.push_back(pc);
        end
    endtask

    task automatic compare_all(input bit r);
        logic [N-1:0]  e_exec, e_busy;
        logic [127:0]  e_pc;
        logic [31:0]   e_disp, e_stall;
        e_pc = '0;
        for (int i = 0; i < N; i++) begin
            e_exec[i]        = m_launch[i];
            e_busy[i]        = m_busy[i];
            e_pc[32*i +: 32] = m_pc[i];
        end
`ifdef DISPATCH_PERF_EN
        e_disp  = m_disp;
        e_stall = m_stall;
`else
        e_disp  = '0;
        e_stall = '0;
`endif
        check("fork_ready", 128'(bus.fork_ready), 128'(!r && (m_q.size() < Q)));
        check("exec_requested", 128'(bus.exec_requested), 128'(e_exec));
        check("busy_mask", 128'(bus.busy_mask), 128'(e_busy));
        check("requested_pc", 128'(bus.requested_pc), e_pc);
        check("join_done", 128'(bus.join_done), 128'(m_join));
        check("dispatch_count", 128'(bus.dispatch_count), 128'(e_disp));
        check("stall_cycles", 128'(bus.stall_cycles), 128'(e_stall));
    endtask

    // Drive inputs, take one edge, advance the model, then sample 1 time unit later.
    task automatic step(input bit r, input bit fv, input logic [31:0] pc, input bit jr,
                        input logic [N-1:0] en, output bit acc);
        rst               = r;
        bus.fork_valid    = fv;
        bus.fork_pc       = pc;
        bus.join_req      = jr;
        bus.subcore_ended = en;
        @(posedge clk);
        model_edge(r, fv, pc, jr, en, acc);
        #1;
        compare_all(r);
    endtask

    initial begin
        bit          acc, fv_h, jr, r;
        logic [31:0] pc_h;
        logic [N-1:0] en;
        int          waited;

        // Reset
        step(1, 0, 0, 0, '0, acc);
        step(1, 0, 0, 0, '0, acc);
        check("rst_ready", 128'(bus.fork_ready), 128'(0));
        step(0, 0, 0, 0, '0, acc);
        check("rst_busy", 128'(bus.busy_mask), 128'(0));

        // Single fork
        step(0, 1, 32'h100, 0, '0, acc);
        step(0, 0, 0, 0, '0, acc);
        check("sf_exec", 128'(bus.exec_requested), 128'(4'b0001));
        check("sf_pc", 128'(bus.requested_pc[31:0]), 128'(32'h100));
        step(0, 0, 0, 0, '0, acc);
        check("sf_exec_off", 128'(bus.exec_requested), 128'(0));
        check("sf_busy", 128'(bus.busy_mask), 128'(4'b0001));
        step(0, 0, 0, 0, 4'b0001, acc);
        check("sf_free", 128'(bus.busy_mask), 128'(0));

        // Round-robin: five back-to-back forks
        step(1, 0, 0, 0, '0, acc);
        for (int k = 0; k < 5; k++) begin
            step(0, 1, 32'(16 * (k + 1)), 0, '0, acc);
            if (k > 0) check("rr_launch", 128'(bus.exec_requested), 128'(4'b0001 << (k - 1)));
        end
        for (int k = 0; k < 3; k++) step(0, 0, 0, 0, '0, acc);
        step(0, 0, 0, 0, 4'b0100, acc);
        step(0, 0, 0, 0, '0, acc);
        check("rr_relaunch", 128'(bus.exec_requested), 128'(4'b0100));
        check("rr_pc2", 128'(bus.requested_pc[95:64]), 128'(32'h50));

        // Backpressure: all busy, fill the queue, hold a fifth
        for (int k = 0; k < 4; k++) step(0, 1, 32'h200 + 32'(k), 0, '0, acc);
        check("bp_full", 128'(bus.fork_ready), 128'(0));
        for (int k = 0; k < 3; k++) step(0, 1, 32'h2ff, 0, '0, acc);
        step(0, 1, 32'h2ff, 0, 4'b0001, acc);
        waited = 0;
        acc    = 0;
        while (!acc && waited < 6) begin
            step(0, 1, 32'h2ff, 0, '0, acc);
            waited++;
        end
        check("bp_accept_delay", 128'(waited), 128'(2));

        // Join barrier
        step(1, 0, 0, 0, '0, acc);
        step(0, 1, 32'hA0, 0, '0, acc);
        step(0, 1, 32'hB0, 0, '0, acc);
        step(0, 0, 0, 1, '0, acc);
        step(0, 0, 0, 1, '0, acc);
        check("join_wait", 128'(bus.join_done), 128'(0));
        step(0, 0, 0, 1, 4'b0001, acc);
        step(0, 0, 0, 1, 4'b0010, acc);
        check("join_last_end", 128'(bus.join_done), 128'(0));
        step(0, 0, 0, 1, '0, acc);
        check("join_rise", 128'(bus.join_done), 128'(1));
        step(0, 1, 32'hC0, 1, '0, acc);
        check("join_fork_block", 128'(bus.join_done), 128'(0));

        // Reset mid-operation
        step(1, 0, 0, 0, '0, acc);
        for (int k = 0; k < 5; k++) step(0, 1, 32'h300 + 32'(k), 0, '0, acc);
        step(1, 0, 0, 0, '0, acc);
        check("midrst_busy", 128'(bus.busy_mask), 128'(0));
        check("midrst_pc", 128'(bus.requested_pc), 128'(0));
        for (int k = 0; k < 3; k++) step(0, 0, 0, 0, '0, acc);
        check("midrst_quiet", 128'(bus.exec_requested), 128'(0));
        step(0, 1, 32'h400, 0, '0, acc);
        step(0, 0, 0, 0, '0, acc);
        check("midrst_sub0", 128'(bus.exec_requested), 128'(4'b0001));

        // Ended ignored outside RUN
        step(1, 0, 0, 0, '0, acc);
        step(0, 1, 32'h1, 0, '0, acc);
        step(0, 1, 32'h2, 0, 4'b0010, acc);
        step(0, 0, 0, 0, 4'b0010, acc);
        step(0, 0, 0, 0, 4'b0010, acc);
        check("end_ign_run", 128'(bus.busy_mask[1]), 128'(1));
        step(0, 0, 0, 0, 4'b0010, acc);
        check("end_ign_free", 128'(bus.busy_mask[1]), 128'(0));

        // Randomized traffic, forks held until accepted
        fv_h = 0;
        pc_h = '0;
        acc  = 1;
        for (int t = 0; t < 500; t++) begin
            if (!fv_h || acc) begin
                fv_h = ($urandom_range(0, 2) != 0);
                pc_h = $urandom;
            end
            jr = ($urandom_range(0, 3) == 0);
            en = N'($urandom) & N'($urandom);
            r  = ($urandom_range(0, 63) == 0);
            step(r, fv_h, pc_h, jr, en, acc);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
